// File: rtl/disaggregator.sv
// Disaggregator: splits one wide word from an upstream FWFT FIFO into
// FETCH_WIDTH narrow words and pushes them downstream, one per cycle.
//
// Parameters
//   DATA_WIDTH  : width of one narrow output word
//   FETCH_WIDTH : narrow words per wide input word (1..16)
//
// Ports
//   clk             : clock, rising edge
//   rst_n           : asynchronous active-low reset
//   sender_data     : wide word at the head of the upstream FIFO
//   sender_empty_n  : upstream FIFO holds at least one word
//   sender_deq      : pops the upstream FIFO at this edge
//   receiver_data   : current narrow word (0 while no word is buffered)
//   receiver_full_n : downstream can accept a word this cycle
//   receiver_enq    : receiver_data is pushed downstream at this edge
//
// Configuration
//   DISAGGREGATOR_MSB_FIRST_EN : when defined, lanes go out from
//   FETCH_WIDTH-1 down to 0; otherwise lane 0 goes out first.
module disaggregator #(
    parameter int DATA_WIDTH  = 16,
    parameter int FETCH_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
    input  logic                            sender_empty_n,
    output logic                            sender_deq,
    output logic [DATA_WIDTH-1:0]           receiver_data,
    input  logic                            receiver_full_n,
    output logic                            receiver_enq
);

    localparam int CW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(FETCH_WIDTH - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    state_t                          state;
    logic [CW-1:0]                   cnt;
    logic [FETCH_WIDTH*DATA_WIDTH-1:0] buffer;
    logic [CW-1:0]                   lane;
    logic                            last;

    assign last = (cnt == LAST);

`ifdef DISAGGREGATOR_MSB_FIRST_EN
    assign lane = LAST - cnt;
`else
    assign lane = cnt;
`endif

    assign receiver_enq = (state == SEND) && receiver_full_n;

    // Reload on the same edge the last lane leaves, so a steady
    // upstream gives one narrow word per cycle with no bubble.
    assign sender_deq = rst_n && sender_empty_n &&
                        ((state == EMPTY) || (last && receiver_enq));

    always_comb begin
        receiver_data = '0;
        if (state == SEND) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (lane == CW'(k)) begin
                    receiver_data = buffer[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            cnt    <= '0;
            buffer <= '0;
        end else if (sender_deq) begin
            buffer <= sender_data;
            cnt    <= '0;
            state  <= SEND;
        end else if (receiver_enq) begin
            if (last) begin
                state <= EMPTY;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_disaggregator.sv
// Directed bench for disaggregator: default-width instance driven from an
// upstream FIFO model with a narrow-word scoreboard, plus a FETCH_WIDTH=1 instance.
module tb_disaggregator;

    localparam int DW = 16;
    localparam int FW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [FW*DW-1:0]  sender_data;
    logic              sender_empty_n;
    logic              sender_deq;
    logic [DW-1:0]     receiver_data;
    logic              receiver_full_n;
    logic              receiver_enq;

    logic [DW-1:0]     s1_data;
    logic              s1_empty_n;
    logic              s1_deq;
    logic [DW-1:0]     r1_data;
    logic              r1_full_n;
    logic              r1_enq;

    disaggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sender_data     (sender_data),
        .sender_empty_n  (sender_empty_n),
        .sender_deq      (sender_deq),
        .receiver_data   (receiver_data),
        .receiver_full_n (receiver_full_n),
        .receiver_enq    (receiver_enq)
    );

    disaggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(1)) dut1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .sender_data     (s1_data),
        .sender_empty_n  (s1_empty_n),
        .sender_deq      (s1_deq),
        .receiver_data   (r1_data),
        .receiver_full_n (r1_full_n),
        .receiver_enq    (r1_enq)
    );

    int tests = 0;
    int fails = 0;

    logic [FW*DW-1:0] up_q[$];
    logic [DW-1:0]    exp_q[$];
    int               lanes_left = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW*DW-1:0] mkword(input int base);
        logic [FW*DW-1:0] w;
        for (int k = 0; k < FW; k++) w[k*DW +: DW] = DW'(base + k);
        return w;
    endfunction

    task automatic push_word(input logic [FW*DW-1:0] w);
        up_q.push_back(w);
        for (int k = 0; k < FW; k++) begin
`ifdef DISAGGREGATOR_MSB_FIRST_EN
            exp_q.push_back(w[(FW-1-k)*DW +: DW]);
`else
            exp_q.push_back(w[k*DW +: DW]);
`endif
        end
    endtask

    task automatic cycle(input logic full);
        logic          exp_enq;
        logic          exp_deq;
        logic [DW-1:0] exp_data;
        @(negedge clk);
        receiver_full_n = full;
        sender_empty_n  = (up_q.size() > 0);
        sender_data     = sender_empty_n ? up_q[0] : '0;
        if (!rst_n) begin
            while (lanes_left > 0) begin
                void'(exp_q.pop_front());
                lanes_left--;
            end
        end
        exp_enq  = rst_n && (lanes_left > 0) && full;
        exp_deq  = rst_n && sender_empty_n &&
                   ((lanes_left == 0) || (lanes_left == 1 && exp_enq));
        exp_data = (lanes_left > 0) ? exp_q[0] : '0;
        #1;
        check("enq", 64'(receiver_enq), 64'(exp_enq));
        check("deq", 64'(sender_deq), 64'(exp_deq));
        check("data", 64'(receiver_data), 64'(exp_data));
        @(posedge clk);
        if (exp_enq) begin
            void'(exp_q.pop_front());
            lanes_left--;
        end
        if (exp_deq) begin
            void'(up_q.pop_front());
            lanes_left += FW;
        end
    endtask

    initial begin
        int            first_deq;
        int            first_enq;
        logic [DW-1:0] next_in;
        logic [DW-1:0] exp_out;

        rst_n           = 1'b0;
        sender_data     = '0;
        sender_empty_n  = 1'b0;
        receiver_full_n = 1'b1;
        s1_data         = '0;
        s1_empty_n      = 1'b0;
        r1_full_n       = 1'b1;

        // reset with words waiting: no pop, no push, zero data
        push_word(mkword(0));
        push_word(mkword(4));
        cycle(1'b1);
        cycle(1'b1);
        #1 rst_n = 1'b1;

        // two back-to-back words, no bubble between them
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(1'b1);
        check("drain_seq", 64'(exp_q.size()), 64'd0);

        // single word then upstream empty: idle afterwards
        push_word(mkword(20));
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(1'b1);
        check("drain_single", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 5; i++) cycle(1'b1);

        // counting stream with random stalls
        for (int w = 0; w < 8; w++) push_word(mkword(32 + 4*w));
        for (int i = 0; i < 400 && exp_q.size() > 0; i++)
            cycle(1'($urandom_range(0, 1)));
        check("drain_stall", 64'(exp_q.size()), 64'd0);

        // reset after two lanes of {13,12,11,10}
        push_word(mkword(10));
        for (int i = 0; i < 10; i++) begin
            if (lanes_left == 2) break;
            cycle(1'b1);
        end
        check("pre_rst_lanes", 64'(lanes_left), 64'd2);
        push_word(mkword(14));
        #1 rst_n = 1'b0;
        sender_empty_n = 1'b1;
        sender_data    = up_q[0];
        #1;
        check("rst_data", 64'(receiver_data), 64'd0);
        check("rst_enq", 64'(receiver_enq), 64'd0);
        check("rst_deq", 64'(sender_deq), 64'd0);
        cycle(1'b1);
        cycle(1'b1);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(1'b1);
        check("drain_post_rst", 64'(exp_q.size()), 64'd0);

        // FETCH_WIDTH=1 pass-through, values 0..9
        first_deq = -1;
        first_enq = -1;
        next_in   = '0;
        exp_out   = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            s1_empty_n = (next_in < 16'd10);
            s1_data    = next_in;
            #1;
            check("fw1_deq", 64'(s1_deq), 64'(s1_empty_n));
            if (r1_enq) begin
                if (first_enq < 0) first_enq = c;
                check("fw1_data", 64'(r1_data), 64'(exp_out));
                check("fw1_consec", 64'(c), 64'(first_enq + int'(exp_out)));
                exp_out++;
            end
            if (s1_deq && first_deq < 0) first_deq = c;
            @(posedge clk);
            if (s1_deq) next_in++;
        end
        s1_empty_n = 1'b0;
        check("fw1_count", 64'(exp_out), 64'd10);
        check("fw1_latency", 64'(first_enq), 64'(first_deq + 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
